// File: rtl/uart_rx_if.sv
// Serial line plus the one-entry byte-buffer handshake of the UART receiver.
interface uart_rx_if;
    logic       uart_rx;
    logic [7:0] recv_data;
    logic       recv_valid;
    logic       recv_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    modport slave (
        input  uart_rx, recv_ready,
        output recv_data, recv_valid, frame_err, overrun, busy
    );

    modport master (
        output uart_rx, recv_ready,
        input  recv_data, recv_valid, frame_err, overrun, busy
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-entry valid/ready byte buffer, framing-error and overrun pulses.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around every sample point.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.slave  rx_bus
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
`ifdef UART_RX_MAJORITY_EN
    localparam int LATE = 1;
`else
    localparam int LATE = 0;
`endif
    localparam logic [CNT_W-1:0] START_PT = CNT_W'(CLKS_PER_BIT / 2 - 1 + LATE);
    localparam logic [CNT_W-1:0] BIT_PT   = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;
    logic [1:0]       sync_q;
    logic             rxs;
    logic             sample;
    logic             deliver;
    logic             consume;

    assign rxs = sync_q[1];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], rx_bus.uart_rx};
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) hist_q <= 2'b11;
        else     hist_q <= {hist_q[0], rxs};
    end

    // Vote over the three cycles ending at the decision cycle (mid-1, mid, mid+1).
    assign sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs) | (hist_q[0] & rxs);
`else
    assign sample = rxs;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        deliver = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rxs) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == START_PT) begin
                    cnt_d = '0;
                    if (!sample) begin
                        state_d = S_DATA;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_PT) begin
                    cnt_d   = '0;
                    shift_d = {sample, shift_q[7:1]};
                    if (idx_q == 3'd7) state_d = S_STOP;
                    else               idx_d   = idx_q + 3'd1;
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_PT) begin
                    cnt_d = '0;
                    if (sample) begin
                        deliver = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                cnt_d = '0;
                if (rxs) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A delivery wins over a plain consume; a full, unconsumed buffer drops the new byte.
    assign consume = valid_q & rx_bus.recv_ready;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        if (deliver) begin
            if (!valid_q || consume) begin
                data_d  = shift_d;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (consume) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx_bus.recv_data  = data_q;
    assign rx_bus.recv_valid = valid_q;
    assign rx_bus.frame_err  = ferr_q;
    assign rx_bus.overrun    = ovr_q;
    assign rx_bus.busy       = (state_q != S_IDLE);

endmodule
